// File: rtl/bank_stream_reader.sv
// bank_stream_reader: reads a run of blocks from one memory bank, spreading the reads across its sub-banks
// in block-interleaved order, and returns the lines in order on a valid/ready stream.
// Memory reads are issued on a credit basis, so the output FIFO can never overflow.
//   clk_i, rst_ni          : clock; asynchronous active-low reset
//   start_i                : command pulse, accepted only while busy_o is low
//   base_blk_i, num_blks_i : first global block index and number of blocks to read
//   busy_o, done_o         : busy_o is high while a command runs; done_o pulses for one cycle at the final hand-off
//   re_bus_o, raddr_bus_o  : per-sub-bank read enable (at most one bit set) and address
//   rdata_bus_i            : per-sub-bank read data, valid RD_LAT cycles after the matching enable
//   out_valid_o, out_ready_i, out_data_o : in-order output line stream
module bank_stream_reader #(
   parameter int SUBBANKS_PER_BANK = 8,
   parameter int LINE_WIDTH = 400,
   parameter int DEPTH_PER_SUBBANK = 1024,
   parameter int RD_LAT = 1,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W = 16,
   localparam int AAW = $clog2(DEPTH_PER_SUBBANK),
   localparam int SBW = $clog2(SUBBANKS_PER_BANK),
   localparam int GW = AAW + SBW
) (
   input  logic                                    clk_i,
   input  logic                                    rst_ni,
   input  logic                                    start_i,
   input  logic [GW-1:0]                           base_blk_i,
   input  logic [CNT_W-1:0]                        num_blks_i,
   output logic                                    busy_o,
   output logic                                    done_o,
   output logic [SUBBANKS_PER_BANK-1:0]            re_bus_o,
   output logic [SUBBANKS_PER_BANK*AAW-1:0]        raddr_bus_o,
   input  logic [SUBBANKS_PER_BANK*LINE_WIDTH-1:0] rdata_bus_i,
   output logic                                    out_valid_o,
   input  logic                                    out_ready_i,
   output logic [LINE_WIDTH-1:0]                   out_data_o
);
   localparam int SB = SUBBANKS_PER_BANK;
   localparam int LW = LINE_WIDTH;
   localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int OW = $clog2(FIFO_DEPTH + RD_LAT + 2);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t            state_q, state_d;
   logic [GW-1:0]     g_q, g_d, gi;
   logic [CNT_W-1:0]  iss_left_q, iss_left_d, pop_left_q, pop_left_d;
   logic              zdone_q, zdone_d;
   logic [SB-1:0]     re_q, re_d;
   logic [SB*AAW-1:0] raddr_q, raddr_d;
   logic [SBW-1:0]    idx_q, idx_d;
   logic [RD_LAT-1:0] pv_q;
   logic [SBW-1:0]    pi_q [RD_LAT];
   logic [LW-1:0]     mem_q [FIFO_DEPTH];
   logic [PW-1:0]     wp_q, rp_q;
   logic [CW-1:0]     cnt_q;
   logic [OW-1:0]     outst;
   logic              push, pop, last_pop, accept, issue;

   assign push     = pv_q[RD_LAT-1];
   assign pop      = (cnt_q != '0) && out_ready_i;
   assign last_pop = (state_q == DRAIN) && pop && (pop_left_q == CNT_W'(1));
   assign done_o   = zdone_q || last_pop;
   // busy_o drops in the cycle of the final pop, so that cycle can already accept the next command
   assign busy_o   = (state_q != IDLE) && !last_pop;
   assign accept   = start_i && !busy_o;
   // Every issued read that has not yet left the FIFO holds one credit: this covers the read on the bus now,
   // the reads in the latency pipeline and the lines waiting in the FIFO.
   assign outst    = OW'(|re_q) + OW'($countones(pv_q)) + OW'(cnt_q);

   assign re_bus_o    = re_q;
   assign raddr_bus_o = raddr_q;
   assign out_valid_o = cnt_q != '0;
   assign out_data_o  = out_valid_o ? mem_q[rp_q] : '0;

   always_comb begin
      state_d    = last_pop ? IDLE : state_q;
      g_d        = g_q;
      gi         = g_q;
      iss_left_d = iss_left_q;
      pop_left_d = pop ? pop_left_q - CNT_W'(1) : pop_left_q;
      zdone_d    = 1'b0;
      issue      = (state_q == ISSUE) && (outst < OW'(FIFO_DEPTH));
      if (issue) begin
         g_d        = g_q + GW'(1);
         iss_left_d = iss_left_q - CNT_W'(1);
         state_d    = (iss_left_q == CNT_W'(1)) ? DRAIN : ISSUE;
      end
      // The first read of a command goes out at the accepting edge. Little or nothing is outstanding then,
      // so a credit is always free.
      if (accept) begin
         zdone_d    = num_blks_i == '0;
         issue      = !zdone_d;
         gi         = base_blk_i;
         g_d        = base_blk_i + GW'(1);
         iss_left_d = num_blks_i - CNT_W'(1);
         pop_left_d = num_blks_i;
         state_d    = zdone_d ? IDLE : (num_blks_i == CNT_W'(1)) ? DRAIN : ISSUE;
      end
      idx_d   = gi[SBW-1:0];
      re_d    = issue ? SB'(1) << gi[SBW-1:0] : '0;
      raddr_d = issue ? (SB*AAW)'(gi[GW-1:SBW]) << (AAW * gi[SBW-1:0]) : '0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         g_q        <= '0;
         iss_left_q <= '0;
         pop_left_q <= '0;
         zdone_q    <= 1'b0;
         re_q       <= '0;
         raddr_q    <= '0;
         idx_q      <= '0;
         pv_q       <= '0;
         for (int k = 0; k < RD_LAT; k++) pi_q[k] <= '0;
         wp_q       <= '0;
         rp_q       <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         g_q        <= g_d;
         iss_left_q <= iss_left_d;
         pop_left_q <= pop_left_d;
         zdone_q    <= zdone_d;
         re_q       <= re_d;
         raddr_q    <= raddr_d;
         idx_q      <= idx_d;
         // The sub-bank index follows each read down the pipeline, so the matching data slice is picked
         // exactly RD_LAT cycles later.
         pv_q[0]    <= |re_q;
         pi_q[0]    <= idx_q;
         for (int k = 1; k < RD_LAT; k++) begin
            pv_q[k] <= pv_q[k-1];
            pi_q[k] <= pi_q[k-1];
         end
         if (push) wp_q <= (wp_q == PW'(FIFO_DEPTH - 1)) ? '0 : wp_q + PW'(1);
         if (pop) rp_q <= (rp_q == PW'(FIFO_DEPTH - 1)) ? '0 : rp_q + PW'(1);
         cnt_q      <= cnt_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wp_q] <= rdata_bus_i[pi_q[RD_LAT-1]*LW +: LW];
   end

   assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && cnt_q == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_bank_stream_reader.sv
// tb_bank_stream_reader: scoreboard bench for bank_stream_reader. It drives one instance with the default
// latency and a second instance with RD_LAT=3.
module tb_bank_stream_reader;
   localparam int SB = 8, LW = 400, AAW = 10, GW = 13;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   logic             st0, busy0, done0, ov0, rdy0;
   logic [GW-1:0]    base0;
   logic [15:0]      num0;
   logic [SB-1:0]    re0;
   logic [SB*AAW-1:0] ra0;
   logic [SB*LW-1:0] mp0;
   logic [LW-1:0]    od0;

   logic             st1, busy1, done1, ov1, rdy1;
   logic [GW-1:0]    base1;
   logic [15:0]      num1;
   logic [SB-1:0]    re1;
   logic [SB*AAW-1:0] ra1;
   logic [SB*LW-1:0] mp1a, mp1b, mp1c;
   logic [LW-1:0]    od1;

   int ncmp = 0, nerr = 0, cyc = 0, rd0 = 0, first0 = 0, last0 = 0;
   logic [LW-1:0] q0[$], q1[$];

   bank_stream_reader u0 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(st0), .base_blk_i(base0), .num_blks_i(num0),
      .busy_o(busy0), .done_o(done0), .re_bus_o(re0), .raddr_bus_o(ra0), .rdata_bus_i(mp0),
      .out_valid_o(ov0), .out_ready_i(rdy0), .out_data_o(od0));

   bank_stream_reader #(.RD_LAT(3), .FIFO_DEPTH(5)) u1 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(st1), .base_blk_i(base1), .num_blks_i(num1),
      .busy_o(busy1), .done_o(done1), .re_bus_o(re1), .raddr_bus_o(ra1), .rdata_bus_i(mp1c),
      .out_valid_o(ov1), .out_ready_i(rdy1), .out_data_o(od1));

   // Memory lines are tagged with their sub-bank and address. Sub-banks that are not enabled return a
   // distinct junk tag, so a wrong slice or a wrong latency shows up as a data error.
   function automatic logic [LW-1:0] mk(input int sb, input int ad);
      logic [15:0] s, a;
      s = sb[15:0];
      a = ad[15:0];
      return {16'hA5C3, {12{s, a}}};
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int s = 0; s < SB; s++) begin
         mp0[s*LW +: LW]  <= re0[s] ? mk(s, int'(ra0[s*AAW +: AAW])) : mk(s, 'hDEAD);
         mp1a[s*LW +: LW] <= re1[s] ? mk(s, int'(ra1[s*AAW +: AAW])) : mk(s, 'hDEAD);
      end
      mp1b <= mp1a;
      mp1c <= mp1b;
   end

   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
      ncmp++;
      if (a !== e) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", nm, a, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start0(input int b, input int n);
      base0 = GW'(b);
      num0 = 16'(n);
      st0 = 1'b1;
      tick();
      st0 = 1'b0;
   endtask

   task automatic wait_done0(input int maxc, output int c);
      c = 0;
      for (int k = 1; k <= maxc; k++) begin
         @(negedge clk);
         if (done0) begin
            c = k;
            return;
         end
      end
   endtask

   always @(negedge clk) begin : mon0
      logic [LW-1:0] e;
      logic ok;
      if (re0 != '0) begin
         ok = 1'b1;
         for (int s = 0; s < SB; s++) if (!re0[s] && ra0[s*AAW +: AAW] != '0) ok = 1'b0;
         chk("re_onehot", 64'($onehot(re0)), 1);
         chk("raddr_clean", 64'(ok), 1);
         if (rd0 == 0) first0 = cyc;
         last0 = cyc;
         rd0 = rd0 + 1;
      end
      if (ov0 && rdy0) begin
         ncmp++;
         if (q0.size() == 0) begin
            nerr++;
            $display("FAIL line0: got unexpected %h", od0);
         end else begin
            e = q0.pop_front();
            if (od0 !== e) begin
               nerr++;
               $display("FAIL line0: got %h expected %h", od0, e);
            end
         end
      end
      if (done0) chk("done_not_busy", 64'(busy0), 0);
   end

   always @(negedge clk) begin : mon1
      logic [LW-1:0] e;
      if (ov1 && rdy1) begin
         ncmp++;
         if (q1.size() == 0) begin
            nerr++;
            $display("FAIL line1: got unexpected %h", od1);
         end else begin
            e = q1.pop_front();
            if (od1 !== e) begin
               nerr++;
               $display("FAIL line1: got %h expected %h", od1, e);
            end
         end
         chk("done1_last_pop", 64'(done1), 64'(q1.size() == 0));
      end else if (done1) chk("done1_spurious", 64'(done1), 0);
   end

   initial begin
      int dc, vc, seen, g;
      logic [LW-1:0] tmp;
      st0 = 0; base0 = '0; num0 = '0; rdy0 = 1'b1;
      st1 = 0; base1 = '0; num1 = '0; rdy1 = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      chk("rst_busy", 64'(busy0), 0);
      chk("rst_done", 64'(done0), 0);
      chk("rst_re", 64'(re0), 0);
      chk("rst_raddr", 64'(|ra0), 0);
      chk("rst_valid", 64'(ov0), 0);
      chk("rst_data", 64'(|od0), 0);
      tick();
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 16; i++) q0.push_back(mk(i % 8, i / 8));
      rd0 = 0;
      start0(0, 16);
      wait_done0(100, dc);
      chk("stream_done_cycle", 64'(dc), 18);
      tick();
      chk("stream_reads", 64'(rd0), 16);
      chk("stream_re_span", 64'(last0 - first0 + 1), 16);
      chk("stream_left", 64'(q0.size()), 0);

      rdy0 = 1'b0;
      rd0 = 0;
      for (int i = 0; i < 10; i++) begin
         g = 3 + i;
         q0.push_back(mk(g % 8, g / 8));
      end
      start0(3, 10);
      repeat (20) @(negedge clk);
      tick();
      chk("bp_reads_stalled", 64'(rd0), 4);
      chk("bp_head_valid", 64'(ov0), 1);
      tmp = mk(3, 0);
      chk("bp_head_data", 64'(od0 == tmp), 1);
      rdy0 = 1'b1;
      wait_done0(200, dc);
      chk("bp_done_seen", 64'(dc > 0), 1);
      tick();
      chk("bp_reads", 64'(rd0), 10);
      chk("bp_left", 64'(q0.size()), 0);

      q0.push_back(mk(6, 1023));
      q0.push_back(mk(7, 1023));
      q0.push_back(mk(0, 0));
      q0.push_back(mk(1, 0));
      rd0 = 0;
      start0(8190, 4);
      wait_done0(50, dc);
      chk("wrap_done_cycle", 64'(dc), 6);
      tick();
      chk("wrap_reads", 64'(rd0), 4);
      chk("wrap_left", 64'(q0.size()), 0);

      rd0 = 0;
      start0(5, 0);
      @(negedge clk);
      chk("zero_done", 64'(done0), 1);
      chk("zero_busy", 64'(busy0), 0);
      @(negedge clk);
      chk("zero_done_pulse", 64'(done0), 0);
      tick();
      chk("zero_reads", 64'(rd0), 0);

      for (int i = 0; i < 4; i++) q0.push_back(mk(i, 2));
      rd0 = 0;
      start0(16, 4);
      start0(100, 7);
      wait_done0(50, dc);
      chk("ign_done_cycle", 64'(dc), 5);
      repeat (6) tick();
      chk("ign_reads", 64'(rd0), 4);
      chk("ign_left", 64'(q0.size()), 0);

      rdy0 = 1'b0;
      rd0 = 0;
      start0(0, 16);
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 64'(busy0), 0);
      chk("midrst_done", 64'(done0), 0);
      chk("midrst_re", 64'(re0), 0);
      chk("midrst_raddr", 64'(|ra0), 0);
      chk("midrst_valid", 64'(ov0), 0);
      chk("midrst_data", 64'(|od0), 0);
      chk("midrst_reads", 64'(rd0), 3);
      tick();
      tick();
      rst_n = 1'b1;
      rdy0 = 1'b1;
      vc = 0;
      repeat (10) begin
         @(negedge clk);
         if (ov0 || done0) vc++;
      end
      chk("post_rst_quiet", 64'(vc), 0);
      chk("post_rst_reads", 64'(rd0), 3);

      for (int i = 0; i < 100; i++) begin
         g = 5 + i;
         q1.push_back(mk(g % 8, g / 8));
      end
      tick();
      base1 = GW'(5);
      num1 = 16'd100;
      st1 = 1'b1;
      tick();
      st1 = 1'b0;
      seen = 0;
      for (int k = 0; k < 3000 && seen == 0; k++) begin
         @(negedge clk);
         if (done1) seen = 1;
         else begin
            @(posedge clk);
            #1;
            rdy1 = 1'($urandom_range(0, 1));
         end
      end
      chk("sweep_done_seen", 64'(seen), 1);
      tick();
      chk("sweep_left", 64'(q1.size()), 0);
      chk("sweep_idle", 64'(busy1), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
